// File: rtl/wb_stage.sv
// Writeback stage: selects result source, waits on load data, drives the register-file write port one cycle after capture.
// Optional macro WB_FWD_EN adds a same-cycle forwarding port mirroring the slot being captured.
module wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic        flush_in,
  input  logic        mem_rd_in,
  input  logic        mem_rvalid_in,
  input  logic [15:0] mem_rdata_in,
  input  logic [15:0] alu_res_in,
  input  logic [15:0] pc2_in,
  input  logic [15:0] imm_eff_in,
  input  logic        rf_we_in,
  input  logic [2:0]  rf_waddr_in,
  input  logic [1:0]  wb_sel_in,
  output logic        stall_out,
  output logic        rf_we_out,
  output logic [2:0]  rf_waddr_out,
  output logic [15:0] rf_wdata_out,
  output logic [15:0] retire_cnt_out
`ifdef WB_FWD_EN
  ,
  output logic        fwd_valid_out,
  output logic [2:0]  fwd_addr_out,
  output logic [15:0] fwd_data_out
`endif
);

  typedef enum logic [0:0] {IDLE, WAIT_RD} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_stall;
  logic        w_capture;
  logic        w_from_hold;
  logic        w_load_wait;

  logic        r_h_we;
  logic [2:0]  r_h_waddr;
  logic [1:0]  r_h_sel;
  logic [15:0] r_h_alu;
  logic [15:0] r_h_pc2;
  logic [15:0] r_h_imm;

  logic        w_cap_we;
  logic [2:0]  w_cap_addr;
  logic [1:0]  w_cap_sel;
  logic [15:0] w_cap_data;

  logic        r_rf_we;
  logic [2:0]  r_rf_waddr;
  logic [15:0] r_rf_wdata;
  logic [15:0] r_retire_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    w_capture    = 1'b0;
    w_from_hold  = 1'b0;
    w_load_wait  = 1'b0;
    case (r_state)
      IDLE: begin
        if (valid_in && !flush_in) begin
          if (mem_rd_in && !mem_rvalid_in) begin
            w_stall      = 1'b1;
            w_load_wait  = 1'b1;
            w_next_state = WAIT_RD;
          end else begin
            w_capture = 1'b1;
          end
        end
      end
      WAIT_RD: begin
        // Flush wins over a coincident rvalid; the load is simply dropped.
        if (flush_in) begin
          w_next_state = IDLE;
        end else if (mem_rvalid_in) begin
          w_capture    = 1'b1;
          w_from_hold  = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_we    <= 1'b0;
      r_h_waddr <= 3'd0;
      r_h_sel   <= 2'd0;
      r_h_alu   <= 16'd0;
      r_h_pc2   <= 16'd0;
      r_h_imm   <= 16'd0;
    end else if (w_load_wait) begin
      r_h_we    <= rf_we_in;
      r_h_waddr <= rf_waddr_in;
      r_h_sel   <= wb_sel_in;
      r_h_alu   <= alu_res_in;
      r_h_pc2   <= pc2_in;
      r_h_imm   <= imm_eff_in;
    end
  end

  assign w_cap_we   = w_from_hold ? r_h_we    : rf_we_in;
  assign w_cap_addr = w_from_hold ? r_h_waddr : rf_waddr_in;
  assign w_cap_sel  = w_from_hold ? r_h_sel   : wb_sel_in;

  always_comb begin
    w_cap_data = 16'd0;
    case (w_cap_sel)
      2'b00:   w_cap_data = w_from_hold ? r_h_alu : alu_res_in;
      2'b01:   w_cap_data = mem_rdata_in;
      2'b10:   w_cap_data = w_from_hold ? r_h_pc2 : pc2_in;
      default: w_cap_data = w_from_hold ? r_h_imm : imm_eff_in;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= 3'd0;
      r_rf_wdata   <= 16'd0;
      r_retire_cnt <= 16'd0;
    end else begin
      r_rf_we <= w_capture & w_cap_we;
      if (w_capture) begin
        r_rf_waddr   <= w_cap_addr;
        r_rf_wdata   <= w_cap_data;
        r_retire_cnt <= r_retire_cnt + 16'd1;
      end
    end
  end

  // Combinational outputs are gated so reset forces them low even with live inputs.
  assign stall_out      = w_stall & rst_n;
  assign rf_we_out      = r_rf_we;
  assign rf_waddr_out   = r_rf_waddr;
  assign rf_wdata_out   = r_rf_wdata;
  assign retire_cnt_out = r_retire_cnt;

`ifdef WB_FWD_EN
  assign fwd_valid_out = w_capture & w_cap_we & rst_n;
  assign fwd_addr_out  = rst_n ? w_cap_addr : 3'd0;
  assign fwd_data_out  = rst_n ? w_cap_data : 16'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected writes queued by stimulus, popped by a negedge monitor.
`timescale 1ns/1ps
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic        flush_in;
  logic        mem_rd_in;
  logic        mem_rvalid_in;
  logic [15:0] mem_rdata_in;
  logic [15:0] alu_res_in;
  logic [15:0] pc2_in;
  logic [15:0] imm_eff_in;
  logic        rf_we_in;
  logic [2:0]  rf_waddr_in;
  logic [1:0]  wb_sel_in;
  logic        stall_out;
  logic        rf_we_out;
  logic [2:0]  rf_waddr_out;
  logic [15:0] rf_wdata_out;
  logic [15:0] retire_cnt_out;
`ifdef WB_FWD_EN
  logic        fwd_valid_out;
  logic [2:0]  fwd_addr_out;
  logic [15:0] fwd_data_out;
`endif

  wb_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .flush_in(flush_in),
    .mem_rd_in(mem_rd_in), .mem_rvalid_in(mem_rvalid_in), .mem_rdata_in(mem_rdata_in),
    .alu_res_in(alu_res_in), .pc2_in(pc2_in), .imm_eff_in(imm_eff_in),
    .rf_we_in(rf_we_in), .rf_waddr_in(rf_waddr_in), .wb_sel_in(wb_sel_in),
    .stall_out(stall_out), .rf_we_out(rf_we_out), .rf_waddr_out(rf_waddr_out),
    .rf_wdata_out(rf_wdata_out), .retire_cnt_out(retire_cnt_out)
`ifdef WB_FWD_EN
    , .fwd_valid_out(fwd_valid_out), .fwd_addr_out(fwd_addr_out), .fwd_data_out(fwd_data_out)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [18:0] exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in = 0; flush_in = 0; mem_rd_in = 0; mem_rvalid_in = 0;
    mem_rdata_in = 16'h0; alu_res_in = 16'h0; pc2_in = 16'h0; imm_eff_in = 16'h0;
    rf_we_in = 0; rf_waddr_in = 3'd0; wb_sel_in = 2'b00;
  endtask

  // Monitor: every register-file write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && rf_we_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {13'd0, rf_waddr_out, rf_wdata_out}, 32'hFFFF_FFFF);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {29'd0, rf_waddr_out}, {29'd0, e[18:16]});
        check("wr_data", {16'd0, rf_wdata_out}, {16'd0, e[15:0]});
      end
    end
  end

  initial begin
    idle_inputs();
    rst_n = 0;
    #3;
    check("rst_stall", {31'd0, stall_out}, 0);
    check("rst_we", {31'd0, rf_we_out}, 0);
    check("rst_addr", {29'd0, rf_waddr_out}, 0);
    check("rst_data", {16'd0, rf_wdata_out}, 0);
    check("rst_cnt", {16'd0, retire_cnt_out}, 0);
    #9 rst_n = 1;
    tick();

    // Test 1: ALU writeback
    valid_in = 1; wb_sel_in = 2'b00; alu_res_in = 16'h1234; rf_waddr_in = 3'd5; rf_we_in = 1;
    pc2_in = 16'h5555; imm_eff_in = 16'hAAAA;
    exp_q.push_back({3'd5, 16'h1234});
    #1 check("t1_stall", {31'd0, stall_out}, 0);
    tick();
    idle_inputs();
    check("t1_we", {31'd0, rf_we_out}, 1);
    check("t1_cnt", {16'd0, retire_cnt_out}, 1);
    tick();
    check("t1_we_one_cycle", {31'd0, rf_we_out}, 0);

    // Test 2: load with three stall cycles
    valid_in = 1; mem_rd_in = 1; wb_sel_in = 2'b01; rf_waddr_in = 3'd3; rf_we_in = 1;
    alu_res_in = 16'h0BAD;
    #1 check("t2_stall_c1", {31'd0, stall_out}, 1);
    tick();
    idle_inputs();
    rf_waddr_in = 3'd7; wb_sel_in = 2'b10; mem_rdata_in = 16'h9999;
    #1 check("t2_stall_c2", {31'd0, stall_out}, 1);
    tick();
    check("t2_stall_c3", {31'd0, stall_out}, 1);
    check("t2_no_early_we", {31'd0, rf_we_out}, 0);
    tick();
    mem_rvalid_in = 1; mem_rdata_in = 16'hBEEF;
    exp_q.push_back({3'd3, 16'hBEEF});
    #1 check("t2_stall_release", {31'd0, stall_out}, 0);
    tick();
    idle_inputs();
    check("t2_we_timing", {31'd0, rf_we_out}, 1);
    check("t2_cnt", {16'd0, retire_cnt_out}, 2);
    tick();

    // Test 3: flush with coincident rvalid
    valid_in = 1; mem_rd_in = 1; wb_sel_in = 2'b01; rf_waddr_in = 3'd2; rf_we_in = 1;
    tick();
    idle_inputs();
    flush_in = 1; mem_rvalid_in = 1; mem_rdata_in = 16'hDEAD;
    #1 check("t3_stall_drop", {31'd0, stall_out}, 0);
    tick();
    flush_in = 0;
    check("t3_no_write", {31'd0, rf_we_out}, 0);
    tick();
    idle_inputs();
    check("t3_late_rvalid_ignored", {31'd0, rf_we_out}, 0);
    check("t3_cnt", {16'd0, retire_cnt_out}, 2);

    // Test 4: pc2 then immediate, back to back
    valid_in = 1; rf_we_in = 1; wb_sel_in = 2'b10; pc2_in = 16'h0042; rf_waddr_in = 3'd1;
    alu_res_in = 16'h1111; imm_eff_in = 16'h2222;
    exp_q.push_back({3'd1, 16'h0042});
    tick();
    wb_sel_in = 2'b11; imm_eff_in = 16'hFFF0; rf_waddr_in = 3'd6; pc2_in = 16'h3333;
    exp_q.push_back({3'd6, 16'hFFF0});
    tick();
    idle_inputs();
    check("t4_we_second", {31'd0, rf_we_out}, 1);
    tick();
    check("t4_cnt", {16'd0, retire_cnt_out}, 4);

    // Test 6: asynchronous reset while waiting on a load
    valid_in = 1; mem_rd_in = 1; wb_sel_in = 2'b01; rf_waddr_in = 3'd4; rf_we_in = 1;
    tick();
    idle_inputs();
    #2 rst_n = 0;
    #1;
    check("t6_stall", {31'd0, stall_out}, 0);
    check("t6_we", {31'd0, rf_we_out}, 0);
    check("t6_addr", {29'd0, rf_waddr_out}, 0);
    check("t6_data", {16'd0, rf_wdata_out}, 0);
    check("t6_cnt", {16'd0, retire_cnt_out}, 0);
    tick();
    rst_n = 1;
    mem_rvalid_in = 1; mem_rdata_in = 16'h1111;
    tick();
    tick();
    check("t6_no_write", {31'd0, rf_we_out}, 0);
    check("t6_cnt_after", {16'd0, retire_cnt_out}, 0);
    idle_inputs();
    tick();

    // Test 5: counter wrap via non-writing retirements
    valid_in = 1; rf_we_in = 0; rf_waddr_in = 3'd7; alu_res_in = 16'h7777;
    repeat (65535) tick();
    idle_inputs();
    check("t5_cnt_max", {16'd0, retire_cnt_out}, 32'h0000_FFFF);
    check("t5_no_write", {31'd0, rf_we_out}, 0);
    valid_in = 1;
    tick();
    idle_inputs();
    check("t5_cnt_wrap", {16'd0, retire_cnt_out}, 0);
    tick();
    tick();

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have the following ports, in order: name, direction, width, meaning.
- clk  in  1  Single clock; all state updates on rising edge.
- rst_n  in  1  Reset, asynchronous, active-low.
- valid_in  in  1  MEM-side instruction valid.
- flush_in  in  1  Kill the instruction currently presented or held.
- mem_rd_in  in  1  Instruction is a load.
- mem_rvalid_in  in  1  Data-memory read data valid this cycle.
- mem_rdata_in  in  16  Data-memory read data.
- alu_res_in  in  16  ALU result.
- pc2_in  in  16  PC+2.
- imm_eff_in  in  16  Effective immediate.
- rf_we_in  in  1  Register write request.
- rf_waddr_in  in  3  Destination register.
- wb_sel_in  in  2  Writeback source select.
- stall_out  out  1  Hold upstream stages.
- rf_we_out  out  1  Register-file write enable.
- rf_waddr_out  out  3  Register-file write address.
- rf_wdata_out  out  16  Register-file write data.
- retire_cnt_out  out  16  Retired-instruction count.
- fwd_valid_out  out  1  Forwarding entry valid (macro only).
- fwd_addr_out  out  3  Forwarding register address (macro only).
- fwd_data_out  out  16  Forwarding data (macro only).

Function
REQ-002 SHALL select writeback data by wb_sel: 00 alu_res, 01 mem_rdata, 10 pc2, 11 imm_eff.
REQ-003 SHALL implement FSM states IDLE and WAIT_RD.
REQ-004 In IDLE, valid_in=1, flush_in=0, mem_rd_in=1, mem_rvalid_in=0: SHALL latch all fields, go to WAIT_RD, and assert stall_out combinationally in that same cycle.
REQ-005 In WAIT_RD, SHALL hold stall_out=1 until mem_rvalid_in=1; on that cycle SHALL capture mem_rdata_in, deassert stall_out, and return to IDLE.
REQ-006 In IDLE, valid_in=1, flush_in=0, and either mem_rd_in=0 or mem_rvalid_in=1: SHALL capture in that cycle with no stall.
REQ-007 Captured instruction SHALL drive rf_we_out/rf_waddr_out/rf_wdata_out for exactly one cycle, the cycle after capture (latency 1).
REQ-008 rf_we_out SHALL equal captured rf_we AND valid; an invalid or flushed slot SHALL give rf_we_out=0.
REQ-009 flush_in=1 in WAIT_RD SHALL abandon the load, return to IDLE, deassert stall_out, produce no write, and ignore late mem_rvalid_in.
REQ-010 Simultaneous flush_in=1 and mem_rvalid_in=1 SHALL give flush priority.
REQ-011 retire_cnt_out SHALL increment by 1 on every cycle rf_we_out or a retiring non-writing valid instruction completes; it SHALL wrap 0xFFFF to 0x0000.
REQ-012 mem_rvalid_in while in IDLE with no load SHALL be ignored.

Reset
REQ-013 rst_n=0 SHALL asynchronously force IDLE, stall_out=0, rf_we_out=0, rf_waddr_out=0, rf_wdata_out=0, retire_cnt_out=0, and fwd_* to 0.
REQ-014 Reset mid-WAIT_RD SHALL discard the pending load; first capture after release follows REQ-004/006.

Configuration
REQ-015 With macro WB_FWD_EN defined, fwd_* SHALL mirror the captured slot one cycle early: valid when a write-enabled instruction is captured this cycle, with its address and selected data.
REQ-016 Without WB_FWD_EN, fwd_* ports SHALL not exist; all other behaviour is unchanged.

Verification
REQ-017 Bench SHALL cover these directed scenarios:
- Test 1: ALU op, wb_sel=00, alu_res=0x1234, waddr=5, rf_we=1 -> next cycle rf_we_out=1, addr=5, data=0x1234; retire_cnt=1.
- Test 2: Load with rvalid low 3 cycles, then rdata=0xBEEF -> stall_out high 3 cycles; write 0xBEEF one cycle after rvalid.
- Test 3: Load waiting, flush_in with rvalid same cycle -> no write, stall_out drops, retire_cnt unchanged.
- Test 4: wb_sel=10 with pc2=0x0042, then wb_sel=11 with imm=0xFFF0 -> back-to-back writes of 0x0042 and 0xFFF0.
- Test 5: retire_cnt preset to 0xFFFF by 65535 retirements, one more retirement -> 0x0000.
- Test 6: rst_n low during WAIT_RD -> outputs zero immediately, without a clock edge; no write after release.
